// File: rtl/pool2x2_stream.sv
// Streaming 2x2 stride-2 pooling over raster-order pixels, CHANNELS lanes, half-width line buffer.
// Average pooling by default; defining POOL_MAX_EN adds the pool_mode port and signed-max pooling.
module pool2x2_stream #(
    parameter int DATA_W   = 16,
    parameter int WIDTH    = 28,
    parameter int HEIGHT   = 28,
    parameter int CHANNELS = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
`ifdef POOL_MAX_EN
    input  logic                       pool_mode,
`endif
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CHANNELS*DATA_W-1:0] in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CHANNELS*DATA_W-1:0] out_data,
    output logic                       out_last
);

    localparam int PAIRS    = WIDTH / 2;
    localparam int CW       = $clog2(WIDTH);
    localparam int RW       = $clog2(HEIGHT);
    localparam int PW       = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam int BW       = DATA_W + 2;
    localparam int LAST_COL = 2 * (WIDTH / 2) - 1;
    localparam int LAST_ROW = 2 * (HEIGHT / 2) - 1;

    // Both ports move a word only on valid && ready; the producer holds data
    // stable while valid is high and not yet accepted, and never retracts valid.
    logic [CW-1:0]              col;
    logic [RW-1:0]              row;
    logic [CHANNELS*DATA_W-1:0] h_all;
    logic [CHANNELS*BW-1:0]     pair_all;
    logic [CHANNELS*DATA_W-1:0] res_all;
    logic [BW-1:0]              lbuf [CHANNELS][PAIRS];
    logic [PW-1:0]              p;
    logic in_hs, col_last, row_last, discard, buf_wr, out_load, last_pos;
`ifdef POOL_MAX_EN
    logic mode_q;
`endif

    assign in_ready = !out_valid || out_ready;
    assign in_hs    = in_valid && in_ready;
    assign col_last = (col == CW'(WIDTH - 1));
    assign row_last = (row == RW'(HEIGHT - 1));
    // Trailing column/row of an odd-sized map never forms a complete window.
    assign discard  = (((WIDTH % 2) == 1) && col_last) || (((HEIGHT % 2) == 1) && row_last);
    assign p        = PW'(col >> 1);
    assign buf_wr   = in_hs && !discard && !row[0] && col[0];
    assign out_load = in_hs && !discard && row[0] && col[0];
    assign last_pos = (row == RW'(LAST_ROW)) && (col == CW'(LAST_COL));

    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        logic signed [DATA_W-1:0] xs, hs;
        logic signed [BW-1:0]     xe, he, bv, pair, quad;
        assign xs = in_data[k*DATA_W +: DATA_W];
        assign hs = h_all[k*DATA_W +: DATA_W];
        assign xe = {{2{xs[DATA_W-1]}}, xs};
        assign he = {{2{hs[DATA_W-1]}}, hs};
        assign bv = lbuf[k][p];
`ifdef POOL_MAX_EN
        assign pair = mode_q ? ((he > xe) ? he : xe) : (he + xe);
        assign quad = mode_q ? ((bv > pair) ? bv : pair) : ((bv + pair) >>> 2);
`else
        assign pair = he + xe;
        assign quad = (bv + pair) >>> 2;
`endif
        assign pair_all[k*BW +: BW]       = pair;
        assign res_all[k*DATA_W +: DATA_W] = DATA_W'(quad);
    end

    always_ff @(posedge clk) begin
        if (buf_wr) begin
            for (int k = 0; k < CHANNELS; k++) begin
                lbuf[k][p] <= pair_all[k*BW +: BW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col   <= '0;
            row   <= '0;
            h_all <= '0;
        end else if (in_hs) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
            if (!discard && !col[0]) begin
                h_all <= in_data;
            end
        end
    end

`ifdef POOL_MAX_EN
    // Mode is latched with pixel (0,0) so a frame is never pooled with mixed modes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= 1'b0;
        end else if (in_hs && col == '0 && row == '0) begin
            mode_q <= pool_mode;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (out_load) begin
            out_valid <= 1'b1;
            out_data  <= res_all;
            out_last  <= last_pos;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pool2x2_stream.sv
// Directed bench for pool2x2_stream: 4x4 and 5x5 single-lane maps plus a 28x28 two-lane random frame.
// Max-mode steps are compiled only when POOL_MAX_EN is defined.
module tb_pool2x2_stream;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // 4x4, one lane
    logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a, out_last_a;
    logic [15:0] in_data_a, out_data_a;
    // 5x5, one lane
    logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_last_b;
    logic [15:0] in_data_b, out_data_b;
    // 28x28, two lanes
    logic        in_valid_c, in_ready_c, out_valid_c, out_ready_c, out_last_c;
    logic [31:0] in_data_c, out_data_c;
`ifdef POOL_MAX_EN
    logic pool_mode_a, pool_mode_b, pool_mode_c;
`endif

    pool2x2_stream #(.DATA_W(16), .WIDTH(4), .HEIGHT(4), .CHANNELS(1)) u_a (
        .clk(clk), .rst_n(rst_n),
`ifdef POOL_MAX_EN
        .pool_mode(pool_mode_a),
`endif
        .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a), .out_last(out_last_a));

    pool2x2_stream #(.DATA_W(16), .WIDTH(5), .HEIGHT(5), .CHANNELS(1)) u_b (
        .clk(clk), .rst_n(rst_n),
`ifdef POOL_MAX_EN
        .pool_mode(pool_mode_b),
`endif
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b), .out_last(out_last_b));

    pool2x2_stream #(.DATA_W(16), .WIDTH(28), .HEIGHT(28), .CHANNELS(2)) u_c (
        .clk(clk), .rst_n(rst_n),
`ifdef POOL_MAX_EN
        .pool_mode(pool_mode_c),
`endif
        .in_valid(in_valid_c), .in_ready(in_ready_c), .in_data(in_data_c),
        .out_valid(out_valid_c), .out_ready(out_ready_c), .out_data(out_data_c), .out_last(out_last_c));

    logic [31:0] exp_q[$];
    logic [31:0] pix [784];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Streams one 4x4 frame back-to-back; pool_mode flips just before pixel tog (-1: never).
    task automatic run4(input logic [15:0] v [16], input logic [15:0] e [4], input int tog);
        int k = 0;
        for (int i = 0; i < 16; i++) begin
`ifdef POOL_MAX_EN
            if (i == tog) pool_mode_a = !pool_mode_a;
`endif
            in_valid_a = 1'b1;
            in_data_a  = v[i];
            @(posedge clk); #1;
            if (((i / 4) % 2 == 1) && ((i % 4) % 2 == 1)) begin
                chk("a_valid", out_valid_a, 1'b1);
                chk("a_data", out_data_a, e[k]);
                chk("a_last", out_last_a, k == 3);
                k++;
            end else begin
                chk("a_idle", out_valid_a, 1'b0);
            end
        end
        in_valid_a = 1'b0;
        @(posedge clk); #1;
        chk("a_drain", out_valid_a, 1'b0);
    endtask

    initial begin
        logic [15:0] ramp [16];
        logic [15:0] negs [16];
        logic [15:0] e_avg [4];
        logic [15:0] e_neg [4];
        logic [15:0] e5 [4];
        logic [31:0] e, held_data;
        logic        held, held_last;
        int idx, got, cyc, stall_left, k5;

        rst_n = 1'b0;
        in_valid_a = 0; in_data_a = 0; out_ready_a = 1;
        in_valid_b = 0; in_data_b = 0; out_ready_b = 1;
        in_valid_c = 0; in_data_c = 0; out_ready_c = 1;
`ifdef POOL_MAX_EN
        pool_mode_a = 0; pool_mode_b = 0; pool_mode_c = 0;
`endif
        for (int i = 0; i < 16; i++) begin
            ramp[i] = 16'(i);
            negs[i] = ((i / 4) % 2 == 0) ? 16'hFFFF : 16'hFFFE;
        end
        e_avg = '{16'd2, 16'd4, 16'd10, 16'd12};
        e_neg = '{16'hFFFE, 16'hFFFE, 16'hFFFE, 16'hFFFE};
        e5    = '{16'd3, 16'd5, 16'd13, 16'd15};

        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        #1;
        chk("rst_valid", out_valid_a, 1'b0);
        chk("rst_data", out_data_a, 16'h0);
        chk("rst_last", out_last_a, 1'b0);
        chk("rst_ready", in_ready_a, 1'b1);
        chk("rst_valid_c", out_valid_c, 1'b0);
        chk("rst_data_c", out_data_c, 32'h0);

        // 4x4 ramp then rows of -1/-2 (floor rounding of -6/4)
        run4(ramp, e_avg, -1);
        run4(negs, e_neg, -1);

`ifdef POOL_MAX_EN
        pool_mode_a = 1'b1;
        run4(ramp, '{16'd5, 16'd7, 16'd13, 16'd15}, 6);
        run4(ramp, e_avg, -1);
`endif

        // 5x5 ramp: column 4 and row 4 dropped
        k5 = 0;
        for (int i = 0; i < 25; i++) begin
            in_valid_b = 1'b1;
            in_data_b  = 16'(i);
            @(posedge clk); #1;
            if ((i / 5) % 2 == 1 && (i % 5) % 2 == 1 && (i / 5) < 4 && (i % 5) < 4) begin
                chk("b_valid", out_valid_b, 1'b1);
                chk("b_data", out_data_b, e5[k5]);
                chk("b_last", out_last_b, k5 == 3);
                k5++;
            end else begin
                chk("b_idle", out_valid_b, 1'b0);
            end
        end
        in_valid_b = 1'b0;
        chk("b_count", k5, 4);

        // Mid-frame reset on the 4x4 instance
        for (int i = 0; i < 6; i++) begin
            in_valid_a = 1'b1;
            in_data_a  = 16'(i);
            @(posedge clk); #1;
        end
        chk("pre_rst_valid", out_valid_a, 1'b1);
        chk("pre_rst_data", out_data_a, 16'd2);
        in_valid_a = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid_a, 1'b0);
        chk("mid_rst_data", out_data_a, 16'h0);
        chk("mid_rst_last", out_last_a, 1'b0);
        chk("mid_rst_ready", in_ready_a, 1'b1);
        @(negedge clk); rst_n = 1'b1;
        run4(ramp, e_avg, -1);

        // 28x28 two-lane random frame with backpressure
        for (int i = 0; i < 784; i++) pix[i] = $urandom();
        for (int r = 0; r < 14; r++) begin
            for (int c = 0; c < 14; c++) begin
                int i0;
                i0 = (2 * r) * 28 + 2 * c;
                for (int k = 0; k < 2; k++) begin
                    int s;
                    s = $signed(pix[i0][k*16 +: 16]) + $signed(pix[i0+1][k*16 +: 16])
                      + $signed(pix[i0+28][k*16 +: 16]) + $signed(pix[i0+29][k*16 +: 16]);
                    s = s >>> 2;
                    e[k*16 +: 16] = s[15:0];
                end
                exp_q.push_back(e);
            end
        end
        idx = 0; got = 0; cyc = 0; stall_left = -1; held = 0; held_data = 0; held_last = 0;
        while (got < 196 && cyc < 6000) begin
            @(negedge clk);
            if (out_valid_c && stall_left < 0) stall_left = 10;
            if (stall_left > 0)       out_ready_c = 1'b0;
            else if (stall_left == 0) out_ready_c = ($urandom_range(0, 3) != 0);
            else                      out_ready_c = 1'b1;
            in_valid_c = (idx < 784) && ($urandom_range(0, 4) != 0);
            in_data_c  = (idx < 784) ? pix[idx] : 32'h0;
            #1;
            if (out_valid_c && !out_ready_c) begin
                chk("c_bp_ready", in_ready_c, 1'b0);
                if (held) begin
                    chk("c_hold_data", out_data_c, held_data);
                    chk("c_hold_last", out_last_c, held_last);
                end
                held = 1; held_data = out_data_c; held_last = out_last_c;
            end else begin
                held = 0;
            end
            if (out_valid_c && out_ready_c) begin
                if (exp_q.size() > 0) e = exp_q.pop_front();
                else e = 32'hDEAD_BEEF;
                chk("c_data", out_data_c, e);
                chk("c_last", out_last_c, got == 195);
                got++;
            end
            if (in_valid_c && in_ready_c) idx++;
            if (stall_left > 0) stall_left--;
            cyc++;
            @(posedge clk);
        end
        in_valid_c = 1'b0;
        out_ready_c = 1'b1;
        chk("c_count", got, 196);
        chk("c_inputs", idx, 784);
        chk("c_queue", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("c_no_dup", out_valid_c, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
